w_matrix_bank: RTL and testbench
================================

// Module: w_matrix_bank
// PURPOSE
// - Parametrised NxN demixing-weight register bank for the FastICA core; holds W in signed fixed point.
// - Seeds W serially (row-major), then accepts per-row updates from the one-unit iteration engine.
// - Per-row convergence detection, sweep/iteration counting, done/timeout reporting to the top controller.
// PARAMETERS
// - N        4    channel count; W is NxN, N >= 2
// - DW       26   word width, two's complement
// - FRAC     13   fractional bits (Q(DW-FRAC).FRAC)
// - TOL      8    convergence tolerance in LSBs; row converged if every |new-old| <= TOL
// - MAX_ITER 64   sweep limit before forced stop; iter_cnt width = $clog2(MAX_ITER+1)
// PORTS
// - clk_b      in   1              clock, rising edge
// - rst_b      in   1              reset, asynchronous, active-high
// - init_b     in   1              start seed load (1-cycle pulse)
// - seed_valid in   1              seed word strobe (SEED state only)
// - seed_data  in   DW             seed word, row-major order
// - upd_valid  in   1              row update offered
// - upd_ready  out  1              row update accepted when upd_valid & upd_ready
// - upd_row    in   $clog2(N)      target row index
// - upd_data   in   N*DW           new row, element k at [k*DW +: DW]
// - w_flat     out  N*N*DW         W, element (r,c) at [(r*N+c)*DW +: DW]
// - row_conv   out  N              per-row converged flags
// - busy       out  1              high in SEED or RUN
// - done       out  1              high in DONE
// - timeout    out  1              DONE reached via MAX_ITER, not convergence
// - iter_cnt   out  $clog2(MAX_ITER+1)  completed sweeps
// BEHAVIOUR
// - Reset: W = identity (diag = 1<<FRAC, else 0), state IDLE, row_conv=0, iter_cnt=0, done/timeout/busy=0, seed index=0.
// - FSM IDLE -> SEED on init_b. init_b from RUN or DONE also -> SEED (restart); ignored while in SEED.
// - Entering SEED: clear row_conv, iter_cnt, timeout, seed index.
// - SEED: each seed_valid writes W[idx/N][idx%N] on that edge, idx++; the write of word N*N-1 moves FSM to RUN.
// - RUN: upd_ready = (state==RUN) & ~init_b (combinational); init_b wins a same-cycle update, which is dropped.
// - Accepted update: row replaced on same edge; row_conv[upd_row] <= (all k: |upd_data[k]-W[upd_row][k]| <= TOL), diff in DW+1 bits, no wrap.
// - upd_row >= N (non power-of-2 N): handshake completes, data discarded, no flag/counter change.
// - Accepted update with upd_row == N-1 ends a sweep: iter_cnt++.
// - Sweep end: if all row_conv (including this update's result) -> DONE, timeout=0;
//   else if iter_cnt+1 == MAX_ITER -> DONE, timeout=1; else stay RUN.
// - DONE: W and flags frozen, upd_ready=0; leave only via init_b or reset.
// - Latency: w_flat/row_conv/iter_cnt reflect an accepted word/row the cycle after the accepting edge.
// - Reset mid-SEED or mid-RUN: immediate return to reset values; partial seed discarded.
// STRUCTURE
// - Shared package fica_pkg: DW, FRAC, ONE_FX = 1<<FRAC, state encoding (IDLE/SEED/RUN/DONE), flat-index helper.
// - Sub-module row_delta_cmp: N parallel abs-difference vs TOL on one row, outputs single in_tol bit; purely combinational.
// - Bank, FSM, seed index and iteration counter stay in w_matrix_bank.
// TESTING
// - Reset then idle: w_flat diag = 0x2000, off-diag 0; busy=0, upd_ready=0.
// - init_b, 16 seeds 1..16 (N=4): W(0,0)=1, W(3,3)=16; RUN entered after 16th word; upd_ready=1.
// - RUN, row 2 update with deltas {+3,-8,0,+8}: row_conv[2]=1; delta +9 on one element: row_conv[2]=0.
// - Full sweep rows 0..3 each within TOL: iter_cnt=1, done=1, timeout=0, upd_ready drops next cycle.
// - MAX_ITER=4, updates always off by 100 LSB: after 4 sweeps done=1, timeout=1, iter_cnt=4.
// - init_b same cycle as upd_valid in RUN: update dropped, SEED entered, flags cleared; rst_b mid-seed -> identity W.

Source files
------------

// File: rtl/fica_pkg.sv
// Shared constants for the FastICA core: default word format, bank FSM encoding
// and the row-major flat-index helper used to address W.
package fica_pkg;

    localparam int DW   = 26;
    localparam int FRAC = 13;
    localparam logic [DW-1:0] ONE_FX = DW'(1) << FRAC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int flat_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/w_matrix_bank_if.sv
// Seed/update/status bundle between the FastICA controller (master) and the W bank (slave).
// Parameters must match those of the w_matrix_bank instance it is bound to.
interface w_matrix_bank_if #(
    parameter int N        = 4,
    parameter int DW       = 26,
    parameter int MAX_ITER = 64
);
    localparam int RW = $clog2(N);
    localparam int IW = $clog2(MAX_ITER + 1);

    logic              init_b;
    logic              seed_valid;
    logic [DW-1:0]     seed_data;
    logic              upd_valid;
    logic              upd_ready;
    logic [RW-1:0]     upd_row;
    logic [N*DW-1:0]   upd_data;
    logic [N*N*DW-1:0] w_flat;
    logic [N-1:0]      row_conv;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [IW-1:0]     iter_cnt;

    modport master (
        output init_b, seed_valid, seed_data, upd_valid, upd_row, upd_data,
        input  upd_ready, w_flat, row_conv, busy, done, timeout, iter_cnt
    );

    modport slave (
        input  init_b, seed_valid, seed_data, upd_valid, upd_row, upd_data,
        output upd_ready, w_flat, row_conv, busy, done, timeout, iter_cnt
    );

endinterface

// File: rtl/row_delta_cmp.sv
// Combinational check that every element of a new row lies within TOL LSBs of the old row.
// Differences are taken in DW+1 bits so opposite-sign extremes cannot wrap.
module row_delta_cmp #(
    parameter int N   = 4,
    parameter int DW  = 26,
    parameter int TOL = 8
) (
    input  logic [N*DW-1:0] new_row,
    input  logic [N*DW-1:0] old_row,
    output logic            in_tol
);
    localparam logic [DW:0] TOL_L = (DW+1)'(TOL);

    logic signed [DW:0] diff [N];
    logic        [DW:0] mag  [N];

    always_comb begin
        in_tol = 1'b1;
        for (int k = 0; k < N; k++) begin
            diff[k] = $signed({new_row[k*DW+DW-1], new_row[k*DW +: DW]})
                    - $signed({old_row[k*DW+DW-1], old_row[k*DW +: DW]});
            mag[k]  = diff[k][DW] ? $unsigned(-diff[k]) : $unsigned(diff[k]);
            if (mag[k] > TOL_L)
                in_tol = 1'b0;
        end
    end

endmodule

// File: rtl/w_matrix_bank.sv
// NxN demixing-weight bank: serial row-major seeding, then per-row updates with convergence/sweep tracking.
// Accepted words/rows are visible one cycle after the accepting edge; upd_ready only in RUN without init_b.
module w_matrix_bank
    import fica_pkg::*;
#(
    parameter int N        = 4,
    parameter int DW       = fica_pkg::DW,
    parameter int FRAC     = fica_pkg::FRAC,
    parameter int TOL      = 8,
    parameter int MAX_ITER = 64
) (
    input  logic             clk_b,
    input  logic             rst_b,
    w_matrix_bank_if.slave   bus
);
    localparam int RW = $clog2(N);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int SW = $clog2(N * N);

    localparam logic [DW-1:0] ONE      = DW'(1) << FRAC;
    localparam logic [RW:0]   N_ROWS   = (RW+1)'(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [SW-1:0] LAST_IDX = SW'(N * N - 1);
    localparam logic [IW-1:0] ITER_LIM = IW'(MAX_ITER);

    logic [1:0]      state;
    logic [DW-1:0]   w_q [N*N];
    logic [SW-1:0]   seed_idx;
    logic [N-1:0]    row_conv_q;
    logic [IW-1:0]   iter_q;
    logic            timeout_q;

    logic [N*DW-1:0] old_row;
    logic [N-1:0]    conv_next;
    logic            in_tol;
    logic            accept;
    logic            row_ok;
    logic            sweep_end;

    assign bus.upd_ready = (state == ST_RUN) & ~bus.init_b;
    assign accept        = bus.upd_valid & bus.upd_ready;
    assign row_ok        = ({1'b0, bus.upd_row} < N_ROWS);
    assign sweep_end     = accept & (bus.upd_row == LAST_ROW);

    // Out-of-range rows (non power-of-2 N) compare against zero; the result is never used.
    always_comb begin
        old_row = '0;
        if (row_ok)
            for (int k = 0; k < N; k++)
                old_row[k*DW +: DW] = w_q[flat_idx(int'(bus.upd_row), k, N)];
    end

    always_comb begin
        conv_next = row_conv_q;
        if (row_ok)
            conv_next[bus.upd_row] = in_tol;
    end

    row_delta_cmp #(.N(N), .DW(DW), .TOL(TOL)) u_cmp (
        .new_row (bus.upd_data),
        .old_row (old_row),
        .in_tol  (in_tol)
    );

    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            state      <= ST_IDLE;
            seed_idx   <= '0;
            row_conv_q <= '0;
            iter_q     <= '0;
            timeout_q  <= 1'b0;
            for (int i = 0; i < N * N; i++)
                w_q[i] <= (i / N == i % N) ? ONE : '0;
        end else if (bus.init_b && state != ST_SEED) begin
            state      <= ST_SEED;
            seed_idx   <= '0;
            row_conv_q <= '0;
            iter_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                ST_SEED: if (bus.seed_valid) begin
                    w_q[seed_idx] <= bus.seed_data;
                    seed_idx      <= seed_idx + SW'(1);
                    if (seed_idx == LAST_IDX)
                        state <= ST_RUN;
                end
                ST_RUN: if (accept && row_ok) begin
                    for (int k = 0; k < N; k++)
                        w_q[flat_idx(int'(bus.upd_row), k, N)] <= bus.upd_data[k*DW +: DW];
                    row_conv_q <= conv_next;
                    if (sweep_end) begin
                        iter_q <= iter_q + IW'(1);
                        if (&conv_next) begin
                            state     <= ST_DONE;
                            timeout_q <= 1'b0;
                        end else if (iter_q + IW'(1) == ITER_LIM) begin
                            state     <= ST_DONE;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N * N; i++) begin : g_flat
        assign bus.w_flat[i*DW +: DW] = w_q[i];
    end

    assign bus.row_conv = row_conv_q;
    assign bus.iter_cnt = iter_q;
    assign bus.timeout  = timeout_q;
    assign bus.busy     = (state == ST_SEED) || (state == ST_RUN);
    assign bus.done     = (state == ST_DONE);

endmodule

// File: tb/tb_w_matrix_bank.sv
// Directed bench for w_matrix_bank (N=4, TOL=8, MAX_ITER=4): seeding, convergence,
// timeout, init_b/update collision and mid-seed reset, with hand-computed expectations.
module tb_w_matrix_bank;

    localparam int N   = 4;
    localparam int DW  = 26;
    localparam int TOL = 8;
    localparam int MI  = 4;

    logic clk_b = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk_b = ~clk_b;

    w_matrix_bank_if #(.N(N), .DW(DW), .MAX_ITER(MI)) bus ();

    w_matrix_bank #(.N(N), .DW(DW), .FRAC(13), .TOL(TOL), .MAX_ITER(MI)) dut (
        .clk_b (clk_b),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int mw [16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] wd(input int v);
        return v[DW-1:0];
    endfunction

    function automatic logic [63:0] fx(input int v);
        return 64'(wd(v));
    endfunction

    function automatic logic [63:0] wel(input int r, input int c);
        return 64'(bus.w_flat[(r*N+c)*DW +: DW]);
    endfunction

    task automatic tick();
        @(posedge clk_b);
        #1;
    endtask

    task automatic pulse_init();
        bus.init_b = 1'b1;
        tick();
        bus.init_b = 1'b0;
    endtask

    task automatic seed_all(input int base, input int step);
        pulse_init();
        for (int i = 0; i < 16; i++) begin
            bus.seed_valid = 1'b1;
            bus.seed_data  = wd(base + i * step);
            mw[i]          = base + i * step;
            tick();
        end
        bus.seed_valid = 1'b0;
    endtask

    task automatic upd(input int r, input int a, input int b, input int c, input int d);
        bus.upd_row   = r[1:0];
        bus.upd_data  = {wd(d), wd(c), wd(b), wd(a)};
        bus.upd_valid = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        mw[r*4+0] = a; mw[r*4+1] = b; mw[r*4+2] = c; mw[r*4+3] = d;
    endtask

    initial begin
        bus.init_b     = 1'b0;
        bus.seed_valid = 1'b0;
        bus.seed_data  = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_row    = '0;
        bus.upd_data   = '0;
        repeat (2) tick();
        rst_b = 1'b0;
        tick();

        // Reset state: identity in Q13.13
        check("rst_w00",   wel(0, 0), 64'h2000);
        check("rst_w33",   wel(3, 3), 64'h2000);
        check("rst_w01",   wel(0, 1), 64'h0);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_rdy",   64'(bus.upd_ready), 64'd0);
        check("rst_iter",  64'(bus.iter_cnt), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);

        // Seed 1..16 row-major
        pulse_init();
        check("seed_busy", 64'(bus.busy), 64'd1);
        check("seed_rdy",  64'(bus.upd_ready), 64'd0);
        for (int i = 0; i < 16; i++) begin
            bus.seed_valid = 1'b1;
            bus.seed_data  = wd(i + 1);
            mw[i]          = i + 1;
            tick();
            if (i == 14) check("seed_not_run", 64'(bus.upd_ready), 64'd0);
        end
        bus.seed_valid = 1'b0;
        check("seed_w00",  wel(0, 0), fx(1));
        check("seed_w12",  wel(1, 2), fx(7));
        check("seed_w33",  wel(3, 3), fx(16));
        check("run_rdy",   64'(bus.upd_ready), 64'd1);

        // Row 2 (9,10,11,12) with deltas +3,-8,0,+8
        upd(2, 12, 2, 11, 20);
        check("r2_conv",   64'(bus.row_conv), 64'b0100);
        check("r2_w20",    wel(2, 0), fx(12));
        check("r2_w23",    wel(2, 3), fx(20));
        check("r2_iter",   64'(bus.iter_cnt), 64'd0);
        upd(2, 21, 2, 11, 20);
        check("r2_conv9",  64'(bus.row_conv), 64'b0000);

        // Converging sweep
        upd(0, 1, 2, 3, 4);
        upd(1, 5, 6, 7, 8);
        upd(2, 21, 2, 11, 20);
        check("sw_part",   64'(bus.row_conv), 64'b0111);
        check("sw_iter0",  64'(bus.iter_cnt), 64'd0);
        check("sw_done0",  64'(bus.done), 64'd0);
        upd(3, 21, 14, 15, 8);
        check("sw_conv",   64'(bus.row_conv), 64'hF);
        check("sw_iter",   64'(bus.iter_cnt), 64'd1);
        check("sw_done",   64'(bus.done), 64'd1);
        check("sw_tmo",    64'(bus.timeout), 64'd0);
        check("sw_busy",   64'(bus.busy), 64'd0);
        check("sw_rdy",    64'(bus.upd_ready), 64'd0);

        // DONE freezes W
        bus.upd_row = 2'd0; bus.upd_data = {N{wd(999)}}; bus.upd_valid = 1'b1;
        tick();
        bus.upd_valid = 1'b0;
        check("frz_w00",   wel(0, 0), fx(1));
        check("frz_w33",   wel(3, 3), fx(8));

        // Restart and run to timeout, every row off by +-100
        pulse_init();
        check("rs_busy",   64'(bus.busy), 64'd1);
        check("rs_conv",   64'(bus.row_conv), 64'd0);
        check("rs_iter",   64'(bus.iter_cnt), 64'd0);
        bus.init_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.seed_valid = 1'b1;
            bus.seed_data  = wd(i - 8);
            mw[i]          = i - 8;
            tick();
        end
        bus.seed_valid = 1'b0;
        check("neg_w00",   wel(0, 0), fx(-8));
        for (int s = 0; s < MI; s++) begin
            for (int r = 0; r < N; r++) begin
                int dl;
                dl = (r % 2 == 1) ? -100 : 100;
                upd(r, mw[r*4] + dl, mw[r*4+1] + dl, mw[r*4+2] + dl, mw[r*4+3] + dl);
            end
            check("to_iter",  64'(bus.iter_cnt), 64'(s + 1));
            check("to_done",  64'(bus.done), (s == MI - 1) ? 64'd1 : 64'd0);
            check("to_conv",  64'(bus.row_conv), 64'd0);
        end
        check("to_tmo",    64'(bus.timeout), 64'd1);
        check("to_w33",    wel(3, 3), fx(mw[15]));
        check("to_w10",    wel(1, 0), fx(-4 - 400));

        // init_b collides with an update in RUN
        seed_all(256, 256);
        upd(1, mw[4], mw[5] + 1, mw[6] - 1, mw[7]);
        check("col_pre",   64'(bus.row_conv), 64'b0010);
        bus.upd_row = 2'd0; bus.upd_data = {N{wd(7)}}; bus.upd_valid = 1'b1;
        bus.init_b  = 1'b1;
        #1;
        check("col_rdy",   64'(bus.upd_ready), 64'd0);
        tick();
        bus.init_b = 1'b0; bus.upd_valid = 1'b0;
        check("col_busy",  64'(bus.busy), 64'd1);
        check("col_seedrdy", 64'(bus.upd_ready), 64'd0);
        check("col_conv",  64'(bus.row_conv), 64'd0);
        check("col_w00",   wel(0, 0), fx(256));

        // Partial seed then asynchronous reset
        for (int i = 0; i < 5; i++) begin
            bus.seed_valid = 1'b1;
            bus.seed_data  = wd(77);
            tick();
        end
        bus.seed_valid = 1'b0;
        check("ps_w01",    wel(0, 1), fx(77));
        #2 rst_b = 1'b1;
        #1;
        check("ar_w00",    wel(0, 0), 64'h2000);
        check("ar_w01",    wel(0, 1), 64'h0);
        check("ar_busy",   64'(bus.busy), 64'd0);
        tick();
        rst_b = 1'b0;
        tick();
        check("ar_idle",   64'(bus.upd_ready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
